pingpong_weight_buffer: RTL and testbench
=========================================

Name: pingpong_weight_buffer

Overview:
- Double-buffered weight store feeding the systolic array's 2:1 output select.
- Two register banks, A and B:
  - the shadow bank is filled sequentially from the weight loader;
  - the active bank is read by the PE-column controller.
- A swap command exchanges the two roles.
- Bank data is steered to the read port through a WIDTH-wide 2:1 select driven by bank_sel.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 16, entries per bank (>=2)
ADDR_W, 4, address/counter width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
wr_valid  input  1  write word offered
wr_ready  output  1  shadow bank can accept a word
wr_data  input  WIDTH  word written into the shadow bank
swap_req  input  1  request to exchange the active and shadow banks
swap_done  output  1  one-cycle pulse: swap taken
rd_en  input  1  read request to the active bank
rd_addr  input  ADDR_W  read address
rd_data  output  WIDTH  registered read data
rd_valid  output  1  rd_data is valid this cycle
bank_sel  output  1  active bank: 0 = A, 1 = B
shadow_full  output  1  shadow bank holds DEPTH fresh words

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: bank_sel=0, wr_cnt=0, shadow_full=0, active_valid=0, swap_done=0, rd_valid=0, rd_data=0. Bank contents are not cleared.
- Shadow bank is always the bank not selected by bank_sel.
- Write handshake:
  - wr_ready = !shadow_full, combinational from registered state.
  - A word is accepted when wr_valid & wr_ready; it goes to shadow[wr_cnt], and wr_cnt increments.
  - On acceptance with wr_cnt==DEPTH-1: wr_cnt wraps to 0 and shadow_full is set next cycle.
  - wr_data is ignored when not accepted.
- Fill state machine (per shadow bank): FILLING (shadow_full=0) -> FULL (shadow_full=1) on the DEPTH-th accepted word. FULL -> FILLING on a taken swap.
- Swap:
  - Taken when swap_req=1 and shadow_full=1 at the clock edge.
  - Next cycle: bank_sel toggles, shadow_full=0, active_valid=1, swap_done=1 for exactly one cycle.
  - swap_req while shadow_full=0 is ignored, with no pulse and no state change; it is not queued.
  - Final write and swap_req in the same cycle: swap is not taken, because shadow_full is still 0 at that edge. The requester must re-assert.
  - A swap_req held high over multiple cycles causes only one swap per fill.
- Read:
  - Latency is 1 cycle. On rd_en=1, rd_data <= (bank_sel ? B[rd_addr] : A[rd_addr]) and rd_valid <= active_valid.
  - When rd_en=0: rd_valid <= 0 and rd_data holds its value.
  - rd_addr >= DEPTH: rd_data <= 0, and rd_valid follows the normal rule.
  - Before the first swap, active_valid=0, so reads return rd_valid=0 (data is don't-care but must not be X-propagating into control).
  - Read in the same cycle as a taken swap: the read uses the pre-swap bank_sel and returns old-active data.
- Writes never target the active bank. The cycle after a swap, writes fill the previously active bank starting at index 0.
- Reset mid-fill or mid-read: all state returns to reset values on that edge. Partial shadow contents are discarded logically (wr_cnt=0), and any rd_valid in flight is dropped.

Test Plan (WIDTH=8, DEPTH=4):
1. Reset, then write 0x11,0x22,0x33,0x44 back-to-back -> wr_ready=1 through the 4th accept; shadow_full=1 and wr_ready=0 the cycle after; bank_sel stays 0.
2. After (1), pulse swap_req -> next cycle bank_sel=1, swap_done=1 for one cycle, shadow_full=0. Then rd_en with rd_addr=2 -> one cycle later rd_data=0x33, rd_valid=1.
3. Before any swap, rd_en with rd_addr=0 -> rd_valid=0. swap_req with shadow_full=0 -> no swap_done and bank_sel unchanged.
4. After (2), fill 0xA0..0xA3 into bank A. Assert rd_en with rd_addr=1 in the same cycle as a taken swap -> rd_data=0x22 (old bank B). The following read of addr 1 returns 0xA1 with bank_sel=0.
5. Present the 4th write and swap_req in the same cycle -> no swap. Re-assert swap_req next cycle -> swap taken. A swap_req held for 3 cycles -> exactly one swap_done.
6. Assert reset after 2 writes -> wr_cnt=0, shadow_full=0, rd_valid=0, bank_sel=0. Then 4 new writes of 0x55 and a swap -> reads of addr 0..3 return 0x55.

Source files
------------

// File: rtl/pingpong_weight_buffer_if.sv
// Bus bundle for the ping-pong weight buffer: loader write port, swap
// handshake, PE-column read port and bank status.
interface pingpong_weight_buffer_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4
);
   logic              wr_valid;
   logic              wr_ready;
   logic [WIDTH-1:0]  wr_data;
   logic              swap_req;
   logic              swap_done;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [WIDTH-1:0]  rd_data;
   logic              rd_valid;
   logic              bank_sel;
   logic              shadow_full;

   // Requester side (loader, swap controller, PE-column reader)
   modport master (
      output wr_valid, wr_data, swap_req, rd_en, rd_addr,
      input  wr_ready, swap_done, rd_data, rd_valid, bank_sel, shadow_full
   );

   // Buffer side
   modport slave (
      input  wr_valid, wr_data, swap_req, rd_en, rd_addr,
      output wr_ready, swap_done, rd_data, rd_valid, bank_sel, shadow_full
   );
endinterface

// File: rtl/pingpong_weight_buffer.sv
// Double-buffered weight store. The shadow bank (the one not selected by
// bank_sel) is filled sequentially; the active bank is read with one cycle
// of latency. A swap is only taken once the shadow bank is full.
module pingpong_weight_buffer #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   pingpong_weight_buffer_if.slave bus
);

   logic [WIDTH-1:0]  bank_a_q [DEPTH];
   logic [WIDTH-1:0]  bank_a_d [DEPTH];
   logic [WIDTH-1:0]  bank_b_q [DEPTH];
   logic [WIDTH-1:0]  bank_b_d [DEPTH];

   logic [ADDR_W-1:0] wr_cnt_q,       wr_cnt_d;
   logic              shadow_full_q,  shadow_full_d;
   logic              bank_sel_q,     bank_sel_d;
   logic              active_valid_q, active_valid_d;
   logic              swap_done_q,    swap_done_d;
   logic              rd_valid_q,     rd_valid_d;
   logic [WIDTH-1:0]  rd_data_q,      rd_data_d;

   logic              wr_accept;
   logic              swap_take;
   logic [WIDTH-1:0]  rd_word;

   // Writes are refused while full, so an accepted write and a taken swap
   // can never coincide.
   assign wr_accept = bus.wr_valid & ~shadow_full_q;
   assign swap_take = bus.swap_req &  shadow_full_q;

   assign bus.wr_ready    = ~shadow_full_q;
   assign bus.swap_done   = swap_done_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.bank_sel    = bank_sel_q;
   assign bus.shadow_full = shadow_full_q;

   // Steer an accepted word into the shadow bank slot addressed by wr_cnt
   always_comb begin
      bank_a_d = bank_a_q;
      bank_b_d = bank_b_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_accept && (wr_cnt_q == ADDR_W'(i))) begin
            if (bank_sel_q) begin
               bank_a_d[i] = bus.wr_data;
            end else begin
               bank_b_d[i] = bus.wr_data;
            end
         end else begin
            bank_a_d[i] = bank_a_q[i];
            bank_b_d[i] = bank_b_q[i];
         end
      end
   end

   // Fill counter, fill state and bank role exchange
   always_comb begin
      wr_cnt_d       = wr_cnt_q;
      shadow_full_d  = shadow_full_q;
      bank_sel_d     = bank_sel_q;
      active_valid_d = active_valid_q;
      swap_done_d    = swap_take;
      if (wr_accept) begin
         if (wr_cnt_q == ADDR_W'(DEPTH - 1)) begin
            wr_cnt_d      = {ADDR_W{1'b0}};
            shadow_full_d = 1'b1;
         end else begin
            wr_cnt_d      = wr_cnt_q + ADDR_W'(1);
         end
      end else if (swap_take) begin
         bank_sel_d     = ~bank_sel_q;
         shadow_full_d  = 1'b0;
         active_valid_d = 1'b1;
      end else begin
         wr_cnt_d       = wr_cnt_q;
      end
   end

   // Active-bank read mux; out-of-range addresses match no slot and read 0
   always_comb begin
      rd_word = {WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.rd_addr == ADDR_W'(i)) begin
            rd_word = bank_sel_q ? bank_b_q[i] : bank_a_q[i];
         end else begin
            rd_word = rd_word;
         end
      end
   end

   // Registered read port: data holds when idle, valid only once a bank is live
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (bus.rd_en) begin
         rd_data_d  = rd_word;
         rd_valid_d = active_valid_q;
      end else begin
         rd_valid_d = 1'b0;
      end
   end

   // Control state with synchronous reset; bank contents are left untouched
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_cnt_q       <= {ADDR_W{1'b0}};
         shadow_full_q  <= 1'b0;
         bank_sel_q     <= 1'b0;
         active_valid_q <= 1'b0;
         swap_done_q    <= 1'b0;
         rd_valid_q     <= 1'b0;
         rd_data_q      <= {WIDTH{1'b0}};
      end else begin
         wr_cnt_q       <= wr_cnt_d;
         shadow_full_q  <= shadow_full_d;
         bank_sel_q     <= bank_sel_d;
         active_valid_q <= active_valid_d;
         swap_done_q    <= swap_done_d;
         rd_valid_q     <= rd_valid_d;
         rd_data_q      <= rd_data_d;
      end
   end

   // Weight storage registers
   always_ff @(posedge clk) begin
      bank_a_q <= bank_a_d;
      bank_b_q <= bank_b_d;
   end

endmodule

// File: tb/tb_pingpong_weight_buffer.sv
// Self-checking bench for pingpong_weight_buffer (WIDTH=8, DEPTH=4).
module tb_pingpong_weight_buffer;
   localparam int W = 8;
   localparam int D = 4;
   localparam int A = 4;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   pingpong_weight_buffer_if #(.WIDTH(W), .ADDR_W(A)) bus ();

   pingpong_weight_buffer #(.WIDTH(W), .DEPTH(D), .ADDR_W(A)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: two banks indexed by role, plain counters
   logic [7:0] m_bank [0:1][0:3];
   int         m_sel, m_cnt, m_full, m_av, m_sd, m_rv;
   logic [7:0] m_rd;

   task automatic step(input logic wv, input logic [7:0] wd, input logic sr,
                       input logic re, input logic [3:0] ra, input logic rs);
      bus.wr_valid = wv;
      bus.wr_data  = wd;
      bus.swap_req = sr;
      bus.rd_en    = re;
      bus.rd_addr  = ra;
      reset        = rs;
      @(posedge clk);
      if (rs) begin
         m_sel = 0; m_cnt = 0; m_full = 0; m_av = 0; m_sd = 0; m_rv = 0; m_rd = 8'h00;
      end else begin
         if (re) begin
            m_rv = m_av;
            m_rd = (int'(ra) < D) ? m_bank[m_sel][ra] : 8'h00;
         end else begin
            m_rv = 0;
         end
         m_sd = (sr && m_full == 1) ? 1 : 0;
         if (wv && m_full == 0) begin
            m_bank[1 - m_sel][m_cnt] = wd;
            m_cnt = m_cnt + 1;
            if (m_cnt == D) begin
               m_cnt  = 0;
               m_full = 1;
            end
         end else if (m_sd == 1) begin
            m_sel  = 1 - m_sel;
            m_full = 0;
            m_av   = 1;
         end
      end
      #1;
   endtask

   task automatic idle();
      step(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0);
   endtask

   task automatic test_reset();
      step(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b1);
      total++; if (bus.bank_sel !== 1'b0) begin bad++; $display("FAIL reset_bank_sel got=%0h exp=0", bus.bank_sel); end
      total++; if (bus.shadow_full !== 1'b0) begin bad++; $display("FAIL reset_shadow_full got=%0h exp=0", bus.shadow_full); end
      total++; if (bus.swap_done !== 1'b0) begin bad++; $display("FAIL reset_swap_done got=%0h exp=0", bus.swap_done); end
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0h exp=0", bus.rd_valid); end
      total++; if (bus.rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%0h exp=00", bus.rd_data); end
      total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%0h exp=1", bus.wr_ready); end
   endtask

   task automatic test_pre_swap();
      step(1'b0, 8'h00, 1'b0, 1'b1, 4'h0, 1'b0);
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL preswap_rd_valid got=%0h exp=0", bus.rd_valid); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0);
      total++; if (bus.swap_done !== 1'b0) begin bad++; $display("FAIL preswap_swap_done got=%0h exp=0", bus.swap_done); end
      total++; if (bus.bank_sel !== 1'b0) begin bad++; $display("FAIL preswap_bank_sel got=%0h exp=0", bus.bank_sel); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < D; i++) begin
         total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL fill_wr_ready[%0d] got=%0h exp=1", i, bus.wr_ready); end
         step(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 4'h0, 1'b0);
      end
      total++; if (bus.shadow_full !== 1'b1) begin bad++; $display("FAIL fill_shadow_full got=%0h exp=1", bus.shadow_full); end
      total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL fill_wr_ready_full got=%0h exp=0", bus.wr_ready); end
      total++; if (bus.bank_sel !== 1'b0) begin bad++; $display("FAIL fill_bank_sel got=%0h exp=0", bus.bank_sel); end
   endtask

   task automatic test_swap_read();
      step(1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0);
      total++; if (bus.bank_sel !== 1'b1) begin bad++; $display("FAIL swap_bank_sel got=%0h exp=1", bus.bank_sel); end
      total++; if (bus.swap_done !== 1'b1) begin bad++; $display("FAIL swap_done_pulse got=%0h exp=1", bus.swap_done); end
      total++; if (bus.shadow_full !== 1'b0) begin bad++; $display("FAIL swap_shadow_full got=%0h exp=0", bus.shadow_full); end
      step(1'b0, 8'h00, 1'b0, 1'b1, 4'h2, 1'b0);
      total++; if (bus.swap_done !== 1'b0) begin bad++; $display("FAIL swap_done_width got=%0h exp=0", bus.swap_done); end
      total++; if (bus.rd_data !== 8'h33) begin bad++; $display("FAIL read_addr2_data got=%0h exp=33", bus.rd_data); end
      total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL read_addr2_valid got=%0h exp=1", bus.rd_valid); end
      step(1'b0, 8'h00, 1'b0, 1'b1, 4'h9, 1'b0);
      total++; if (bus.rd_data !== 8'h00) begin bad++; $display("FAIL read_oob_data got=%0h exp=00", bus.rd_data); end
      total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL read_oob_valid got=%0h exp=1", bus.rd_valid); end
      step(1'b0, 8'h00, 1'b0, 1'b1, 4'h3, 1'b0);
      step(1'b0, 8'hEE, 1'b0, 1'b0, 4'h0, 1'b0);
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL read_idle_valid got=%0h exp=0", bus.rd_valid); end
      total++; if (bus.rd_data !== 8'h44) begin bad++; $display("FAIL read_idle_hold got=%0h exp=44", bus.rd_data); end
   endtask

   task automatic test_swap_with_read();
      for (int i = 0; i < D; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 4'h0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b1, 4'h1, 1'b0);
      total++; if (bus.rd_data !== 8'h22) begin bad++; $display("FAIL swaprd_old_data got=%0h exp=22", bus.rd_data); end
      total++; if (bus.swap_done !== 1'b1) begin bad++; $display("FAIL swaprd_swap_done got=%0h exp=1", bus.swap_done); end
      step(1'b0, 8'h00, 1'b0, 1'b1, 4'h1, 1'b0);
      total++; if (bus.rd_data !== 8'hA1) begin bad++; $display("FAIL swaprd_new_data got=%0h exp=a1", bus.rd_data); end
      total++; if (bus.bank_sel !== 1'b0) begin bad++; $display("FAIL swaprd_bank_sel got=%0h exp=0", bus.bank_sel); end
   endtask

   task automatic test_same_cycle_swap();
      int pulses;
      for (int i = 0; i < D - 1; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 4'h0, 1'b0);
      step(1'b1, 8'hB3, 1'b1, 1'b0, 4'h0, 1'b0);
      total++; if (bus.swap_done !== 1'b0) begin bad++; $display("FAIL samecyc_no_swap got=%0h exp=0", bus.swap_done); end
      total++; if (bus.shadow_full !== 1'b1) begin bad++; $display("FAIL samecyc_full got=%0h exp=1", bus.shadow_full); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0);
      total++; if (bus.swap_done !== 1'b1) begin bad++; $display("FAIL reassert_swap got=%0h exp=1", bus.swap_done); end
      total++; if (bus.bank_sel !== 1'b1) begin bad++; $display("FAIL reassert_bank_sel got=%0h exp=1", bus.bank_sel); end
      for (int i = 0; i < D; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 4'h0, 1'b0);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0);
         if (bus.swap_done === 1'b1) pulses++;
      end
      total++; if (pulses !== 1) begin bad++; $display("FAIL held_swap_pulses got=%0d exp=1", pulses); end
      total++; if (bus.bank_sel !== 1'b0) begin bad++; $display("FAIL held_swap_bank_sel got=%0h exp=0", bus.bank_sel); end
   endtask

   task automatic test_reset_mid_fill();
      step(1'b1, 8'hD0, 1'b0, 1'b0, 4'h0, 1'b0);
      step(1'b1, 8'hD1, 1'b0, 1'b1, 4'h0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 4'h0, 1'b1);
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_rd_valid got=%0h exp=0", bus.rd_valid); end
      total++; if (bus.shadow_full !== 1'b0) begin bad++; $display("FAIL midrst_full got=%0h exp=0", bus.shadow_full); end
      total++; if (bus.bank_sel !== 1'b0) begin bad++; $display("FAIL midrst_bank_sel got=%0h exp=0", bus.bank_sel); end
      for (int i = 0; i < D; i++) begin
         total++; if (bus.shadow_full !== 1'b0) begin bad++; $display("FAIL midrst_cnt[%0d] got=%0h exp=0", i, bus.shadow_full); end
         step(1'b1, 8'h55, 1'b0, 1'b0, 4'h0, 1'b0);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < D; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b1, 4'(i), 1'b0);
         total++; if (bus.rd_data !== 8'h55 || bus.rd_valid !== 1'b1) begin
            bad++; $display("FAIL midrst_read[%0d] got=%0h/%0h exp=55/1", i, bus.rd_data, bus.rd_valid);
         end
      end
   endtask

   task automatic test_random();
      logic wv, sr, re, rs;
      for (int n = 0; n < 400; n++) begin
         wv = ($urandom_range(3) != 0);
         sr = ($urandom_range(3) == 0);
         re = $urandom_range(1);
         rs = ($urandom_range(63) == 0);
         total++; if (bus.wr_ready !== (m_full == 0)) begin bad++; $display("FAIL rnd_wr_ready[%0d] got=%0h exp=%0h", n, bus.wr_ready, m_full == 0); end
         step(wv, 8'($urandom), sr, re, 4'($urandom_range(6)), rs);
         total++; if (bus.bank_sel !== 1'(m_sel) || bus.shadow_full !== 1'(m_full) || bus.swap_done !== 1'(m_sd) || bus.rd_valid !== 1'(m_rv)) begin
            bad++; $display("FAIL rnd_ctrl[%0d] got sel/full/done/rv=%0h%0h%0h%0h exp=%0h%0h%0h%0h", n, bus.bank_sel, bus.shadow_full, bus.swap_done, bus.rd_valid, m_sel, m_full, m_sd, m_rv);
         end
         if (m_rv == 1) begin
            total++; if (bus.rd_data !== m_rd) begin bad++; $display("FAIL rnd_rd_data[%0d] got=%0h exp=%0h", n, bus.rd_data, m_rd); end
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.wr_valid = 1'b0;
      bus.wr_data  = 8'h00;
      bus.swap_req = 1'b0;
      bus.rd_en    = 1'b0;
      bus.rd_addr  = 4'h0;
      for (int b = 0; b < 2; b++) for (int i = 0; i < D; i++) m_bank[b][i] = 8'h00;
      test_reset();
      test_pre_swap();
      test_fill();
      test_swap_read();
      test_swap_with_read();
      test_same_cycle_swap();
      test_reset_mid_fill();
      test_random();
      idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
